seg7_scan_ctrl: RTL

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one BCD-to-segment decode path across NUM_DIGITS digits. It latches a display word through a tear-free load/commit handshake, inserts ghosting dead-time between digits, and optionally blanks leading zeros. It sits between the counter/arithmetic datapaths and the board display pins.

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/bcd_seg_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment constants, scan state type and BCD decode
package seg7_pkg;

  // Active-low segment patterns, bit order gfedcba
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Non-decimal codes (A-F) fall through to blank so 4'hF doubles as "off"
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// rtl/bcd_seg_decode.sv - combinational BCD to active-low 7-segment decoder
module bcd_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  assign seg_n = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with dead-time and tear-free update
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank_en,
  output logic                    upd_pending,
  output logic                    frame_start,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   dig_en_n
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  scan_state_t           state;
  scan_state_t           state_nxt;
  logic [3:0]            disp [NUM_DIGITS];
  logic [3:0]            pend [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  hi_dark;
  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            dec_in;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_d;
  logic                  dp_d;
  logic [NUM_DIGITS-1:0] dig_d;

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  // Slot prescaler and digit index; idx advances on each slot boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= wrap ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // State register; with no dead-time the controller never enters BLANK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (BLANK_CYCLES > 0) state <= BLANK;
      else                  state <= SHOW;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave BLANK as cnt reaches BLANK_CYCLES, re-enter it at the slot boundary
  always_comb begin
    state_nxt = state;
    if (BLANK_CYCLES == 0) begin
      state_nxt = SHOW;
    end else begin
      case (state)
        BLANK:   if (cnt == BLANK_LAST) state_nxt = SHOW;
        SHOW:    if (slot_end) state_nxt = BLANK;
        default: state_nxt = BLANK;
      endcase
    end
  end

  // Pending capture and frame-wrap commit; a load in the commit cycle re-arms pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        disp[k] <= 4'hF;
        pend[k] <= 4'hF;
      end
      disp_dp     <= '0;
      pend_dp     <= '0;
      upd_pending <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap && upd_pending) begin
        for (int k = 0; k < NUM_DIGITS; k++) disp[k] <= pend[k];
        disp_dp <= pend_dp;
      end
      if (load) begin
        for (int k = 0; k < NUM_DIGITS; k++) pend[k] <= bcd_in[4*k +: 4];
        pend_dp     <= dp_in;
        upd_pending <= 1'b1;
      end else if (wrap) begin
        upd_pending <= 1'b0;
      end
    end
  end

  // Leading-zero mask from the committed word; a higher digit that is zero or non-decimal counts as dark
  always_comb begin
    lz_mask = '0;
    hi_dark = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_mask[k] = lz_blank_en && hi_dark && (disp[k] == 4'h0);
      hi_dark    = hi_dark && ((disp[k] == 4'h0) || (disp[k] > 4'd9));
    end
  end

  assign dec_in = lz_mask[idx] ? 4'hF : disp[idx];

  bcd_seg_decode u_decode (
    .bcd   (dec_in),
    .seg_n (dec_seg)
  );

  // Output decode: everything dark during dead-time, otherwise drive the indexed digit
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    dig_d = '1;
    if (state == SHOW) begin
      seg_d = dec_seg;
      dp_d  = ~disp_dp[idx];
      for (int k = 0; k < NUM_DIGITS; k++) dig_d[k] = (idx != IW'(k));
    end
  end

  // Registered pin drivers, one cycle behind cnt/idx/state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n    <= SEG_BLANK;
      dp_n     <= 1'b1;
      dig_en_n <= '1;
    end else begin
      seg_n    <= seg_d;
      dp_n     <= dp_d;
      dig_en_n <= dig_d;
    end
  end

endmodule
